// File: rtl/sisc_ctrl_fsm.sv
// SISC multi-cycle control unit.
// Sequences fetch/decode/execute/mem/writeback and drives datapath controls.
module sisc_ctrl_fsm #(
    parameter int OPW     = 4,
    parameter int MMW     = 4,
    parameter int ALUOPW  = 2,
    parameter int MEM_LAT = 1,
    parameter int AM_IMM  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic [MMW-1:0]    mm,
    input  logic [MMW-1:0]    stat,
    output logic              pc_write,
    output logic              pc_sel,
    output logic              br_sel,
    output logic              ir_load,
    output logic              rf_we,
    output logic              wb_sel,
    output logic [ALUOPW-1:0] alu_op,
    output logic              stat_en,
    output logic              rd_sel,
    output logic              dm_we,
    output logic              halted,
    output logic [2:0]        state
);

    localparam int CW = $clog2(MEM_LAT) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MEM_LAT - 1);

    localparam logic [OPW-1:0] OP_LOD = OPW'(1);
    localparam logic [OPW-1:0] OP_STR = OPW'(2);
    localparam logic [OPW-1:0] OP_BRA = OPW'(4);
    localparam logic [OPW-1:0] OP_BRR = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE = OPW'(6);
    localparam logic [OPW-1:0] OP_BNR = OPW'(7);
    localparam logic [OPW-1:0] OP_ALU = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);
    localparam logic [MMW-1:0] MM_IMM = MMW'(AM_IMM);

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic is_lod, is_str, is_alu, is_hlt;
    logic is_bra, is_brr, is_bne, is_bnr;
    logic is_ls, is_br, cond, taken, mem_done;

    // Instruction decode and branch condition evaluation
    always_comb begin
        is_lod   = (opcode == OP_LOD);
        is_str   = (opcode == OP_STR);
        is_alu   = (opcode == OP_ALU);
        is_hlt   = (opcode == OP_HLT);
        is_bra   = (opcode == OP_BRA);
        is_brr   = (opcode == OP_BRR);
        is_bne   = (opcode == OP_BNE);
        is_bnr   = (opcode == OP_BNR);
        is_ls    = is_lod | is_str;
        is_br    = is_bra | is_brr | is_bne | is_bnr;
        cond     = |(stat & mm);
        taken    = ((is_bra | is_brr) & cond) | ((is_bne | is_bnr) & ~cond);
        // Non-memory instructions spend exactly one cycle in MEM
        mem_done = ~is_ls | (cnt_q == CNT_MAX);
    end

    // State register and MEM cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and datapath control outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        ir_load  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        alu_op   = '0;
        stat_en  = 1'b0;
        rd_sel   = 1'b0;
        dm_we    = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_START: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (is_hlt) begin
                    state_d = S_HALT;
                end else if (is_br || !(is_ls || is_alu)) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXECUTE;
                end
                if (taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = is_brr | is_bnr;
                end
            end
            S_EXECUTE: begin
                alu_op[1] = is_ls;
                alu_op[0] = (is_alu & (mm == MM_IMM)) | is_ls;
                stat_en   = is_alu;
                rd_sel    = is_str;
                cnt_d     = '0;
                state_d   = S_MEM;
            end
            S_MEM: begin
                rd_sel = is_str;
                wb_sel = is_lod;
                dm_we  = is_str & mem_done;
                if (mem_done) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                rf_we   = is_alu | is_lod;
                wb_sel  = is_lod;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    assign state = state_q;

endmodule
